// File: rtl/seq_det_fsm.sv
// Moore detector for serial pattern 10011001 (MSB first); overlapping matches pulse seq_detected.
// Optional macro SEQ_DET_CNT_EN adds a saturating 8-bit detect_count output.
module seq_det_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_data,
`ifdef SEQ_DET_CNT_EN
  output logic [7:0] detect_count,
`endif
  output logic       seq_detected
);

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // Fallback states are the longest pattern prefix that is a suffix of the bits seen so far.
  always_comb begin
    next_state = S0;
    case (state)
      S0: next_state = ser_data ? S1 : S0;
      S1: next_state = ser_data ? S1 : S2;
      S2: next_state = ser_data ? S1 : S3;
      S3: next_state = ser_data ? S4 : S0;
      S4: next_state = ser_data ? S5 : S2;
      S5: next_state = ser_data ? S1 : S6;
      S6: next_state = ser_data ? S1 : S7;
      S7: next_state = ser_data ? S8 : S0;
      S8: next_state = ser_data ? S5 : S2;
      default: next_state = S0;
    endcase
  end

  assign seq_detected = (state == S8);

`ifdef SEQ_DET_CNT_EN
  // S8 has no self-loop, so every edge with next_state == S8 is an entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      detect_count <= 8'd0;
    end else if ((next_state == S8) && (detect_count != 8'hFF)) begin
      detect_count <= detect_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_det_fsm.sv
// Directed bench for seq_det_fsm: each driven bit queues its expected seq_detected; a monitor checks after every edge.
`timescale 1ns/1ps
module tb_seq_det_fsm;

  logic       clk;
  logic       rst;
  logic       ser_data;
  logic       seq_detected;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] detect_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  seq_det_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .ser_data     (ser_data),
`ifdef SEQ_DET_CNT_EN
    .detect_count (detect_count),
`endif
    .seq_detected (seq_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one sample per rising edge, taken 1ns after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      check("seq_detected", int'(seq_detected), int'(e));
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_bit(input logic b, input logic e);
    ser_data = b;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic send(input string bits, input string exp);
    for (int i = 0; i < bits.len(); i++) begin
      drive_bit(bits[i] == "1", exp[i] == "1");
    end
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    ser_data = 1'b0;
    exp_q.push_back(1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ser_data = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_seq_detected", int'(seq_detected), 0);
`ifdef SEQ_DET_CNT_EN
    check("reset_count", int'(detect_count), 0);
`endif
    rst = 1'b0;

    send("10011001", "00000001");
    send("10011101", "00010000");
    send("11011001", "00000000");

    send("00000000", "00000000");
    send("10011001", "00000001");
    send("11111111", "00000000");
    send("10000001", "00000000");

    send("100110011001", "000000010001");

    send("00000000", "00000000");
    send("1001100", "0000000");
    reset_cycle();
    send("1", "0");
    send("0011001", "0000001");

    // Now sitting in S8: reset must clear the output without a clock edge.
    check("pre_async_rst", int'(seq_detected), 1);
    rst = 1'b1;
    #1;
    check("async_rst_clear", int'(seq_detected), 0);
    exp_q.push_back(1'b0);
    @(negedge clk);
    rst = 1'b0;
    send("10011001", "00000001");

`ifdef SEQ_DET_CNT_EN
    reset_cycle();
    check("count_after_rst", int'(detect_count), 0);
    send("1001", "0000");
    for (int k = 0; k < 300; k++) begin
      send("1001", (k == 0) ? "0001" : "0001");
      if (k == 9) check("count_10", int'(detect_count), 10);
    end
    check("count_saturated", int'(detect_count), 255);
    reset_cycle();
    check("count_cleared", int'(detect_count), 0);
`endif

    send("00", "00");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected samples left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_fsm.md
SEQ_DET_FSM -- requirements
Module: seq_det_fsm

Interface
REQ-001 Parameters: none; detection pattern fixed at 8'b10011001, first-received bit = MSB.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ser_data  input  1  serial data, one bit sampled per rising clk edge, no valid qualifier.
REQ-005 seq_detected  output  1  high for one cycle when the last 8 sampled bits equal 10011001.
REQ-006 detect_count  output  8  saturating detection count; present only when SEQ_DET_CNT_EN is defined.

Function
REQ-007 Core SHALL be a Moore FSM with nine states S0..S8; Sk = k leading pattern bits matched.
REQ-008 Transitions (state: on 0 / on 1): S0: S0/S1; S1: S2/S1; S2: S3/S1; S3: S0/S4; S4: S2/S5; S5: S6/S1; S6: S7/S1; S7: S0/S8; S8: S2/S5.
REQ-009 Detection SHALL be sliding-window with overlap; S8 falls back to S5 or S2 per REQ-008, never to S0.
REQ-010 seq_detected SHALL be 1 exactly while state is S8, i.e. registered, asserted in the cycle after the edge sampling the 8th matching bit.
REQ-011 Latency: 8th pattern bit sampled at edge N -> seq_detected high from edge N to edge N+1.
REQ-012 Back-to-back overlapping matches (e.g. stream 100110011001) SHALL produce a pulse at every window match, including matches straddling byte boundaries.
REQ-013 Any non-matching bit SHALL follow REQ-008; no other state (illegal encodings) SHALL be reachable; an illegal encoding SHALL return to S0 on the next edge.
REQ-014 seq_detected SHALL be glitch-free (decoded from the state register only, no combinational path from ser_data).

Reset
REQ-015 rst high SHALL force state to S0 and seq_detected to 0 immediately, independent of clk.
REQ-016 Reset mid-match SHALL discard the partial match; detection after release requires a full 8 new bits.
REQ-017 First bit sampled on the first rising edge with rst low.
REQ-018 detect_count (when compiled in) SHALL reset to 0.

Configuration
REQ-019 Macro SEQ_DET_CNT_EN: when defined, port detect_count exists and increments by 1 on every edge where the state enters S8, saturating at 8'hFF.
REQ-020 Without SEQ_DET_CNT_EN: no detect_count port, no counter logic; detection behaviour identical.

Verification
REQ-021 Reset 5 cycles, send 10011001 MSB-first -> seq_detected high exactly one cycle, the cycle after bit 8.
REQ-022 Then send 10011101 -> one pulse after its 4th bit (overlap window 10011001 with previous byte), low at byte end; then 11011001 -> no pulse at byte end.
REQ-023 Send 10011001 then 11111111 then 10000001 -> single pulse after the first byte only; seq_detected low at both later byte ends.
REQ-024 Send 100110011001 continuously -> two pulses, 4 cycles apart.
REQ-025 Send 1001100, assert rst one cycle, release, send 1 -> no pulse; then send 0011001 -> still none until a full 10011001 is received.
REQ-026 With SEQ_DET_CNT_EN, 300 back-to-back overlapping matches -> detect_count saturates at 255; reset returns it to 0.
